pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 16: width of the control field; this field is zeroed on bubble.
REQ-002 Parameter DATA_W, default 96: width of the data payload (PC, operands, immediate, etc.).
REQ-003 Parameter CNT_W, default 16: width of the bubble statistics counter.
REQ-004 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: synchronous, active-low reset, sampled on the rising CLK edge.
REQ-006 Port in_valid, input, 1: upstream entry present.
REQ-007 Port in_ready, output, 1: stage accepts the upstream entry this cycle.
REQ-008 Port in_ctrl, input, CTRL_W: upstream control field.
REQ-009 Port in_data, input, DATA_W: upstream data field.
REQ-010 Port bubble, input, 1: insert one NOP entry instead of consuming input.
REQ-011 Port flush, input, 1: discard all held entries.
REQ-012 Port out_valid, output, 1: downstream entry present.
REQ-013 Port out_ready, input, 1: downstream consumes the entry.
REQ-014 Port out_ctrl, output, CTRL_W: registered control field.
REQ-015 Port out_data, output, DATA_W: registered data field.
REQ-016 Port bubble_cnt, output, CNT_W: count of NOP entries inserted.

Function
REQ-017 An upstream transfer occurs when in_valid && in_ready, and a downstream transfer occurs when out_valid && out_ready.
REQ-018 Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
REQ-019 Entries leave in acceptance order, with no loss and no duplication.
REQ-020 Flush has highest priority: the next cycle has out_valid=0 and skid empty, in_ready=0 during the flush cycle, and bubble_cnt is unchanged.
REQ-021 Bubble, without flush, forces in_ready=0, and when the output register can load (empty or draining) it loads ctrl=0, data=0, valid=1 and increments bubble_cnt.
REQ-022 A bubble while the output register cannot load has no effect and is not counted.
REQ-023 bubble_cnt saturates at all ones and does not wrap.
REQ-024 out_ctrl and out_data are stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous upstream and downstream transfers sustain one entry per cycle.

Reset
REQ-026 While Reset=0 at an edge, out_valid=0, out_ctrl=0, out_data=0, skid cleared, bubble_cnt=0, and the state machine returns to EMPTY; outputs are never X.
REQ-027 A reset mid-transfer discards all held entries, and in_ready is 0 during the reset cycle.

Configuration
REQ-028 With PIPE_SKID_EN defined, a one-entry skid buffer is present.
REQ-029 With PIPE_SKID_EN, the state machine is EMPTY -> FULL on accept, FULL -> SKID on accept with out_ready=0, SKID -> FULL on drain, FULL -> EMPTY on drain with no accept, and any state -> EMPTY on flush.
REQ-030 With PIPE_SKID_EN, in_ready is registered: in_ready = (state != SKID) && !bubble && !flush, with no combinational path from out_ready to in_ready.
REQ-031 With PIPE_SKID_EN, on a SKID drain the skid entry moves to the output register in the same edge.
REQ-032 Without PIPE_SKID_EN, the stage is a single register with in_ready = (out_ready || !out_valid) && !bubble && !flush, which is combinational from out_ready.

Structure
REQ-033 Package pipe_pkg holds the pipe_state_e enumeration (EMPTY, FULL, SKID) and the NOP constants for the ctrl and data fields.
REQ-034 The skid storage and its valid flag live in sub-module pipe_skid_buf, instantiated only under PIPE_SKID_EN.

Verification
REQ-035 Reset=0 for 2 cycles -> out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0, in_ready=0 during reset and 1 after release.
REQ-036 Stream 8 entries (ctrl=i, data=0x100+i) with out_ready=1 -> outputs appear 1 cycle later, in order, one per cycle.
REQ-037 With PIPE_SKID_EN, accept entry 0xA1 then 0xA2 while out_ready=0 -> state SKID and in_ready=0; then raise out_ready -> 0xA1 then 0xA2 on consecutive cycles.
REQ-038 Bubble for 3 cycles with out_ready=1 -> three out_valid=1 entries with ctrl=0 and data=0, bubble_cnt=3, and no input consumed.
REQ-039 Flush in SKID state with bubble=1 also asserted -> next cycle out_valid=0, state EMPTY, bubble_cnt unchanged.
REQ-040 Drive CNT_W=2 with 5 counted bubbles -> bubble_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// The optional one-entry skid buffer is enabled by defining PIPE_SKID_EN.
package pipe_pkg;

    // Occupancy of the stage: no entry, output register only, output + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Fill bits for a NOP entry; replicated to the field widths at use.
    localparam logic NOP_CTRL_BIT = 1'b0;
    localparam logic NOP_DATA_BIT = 1'b0;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid storage holding an entry that arrived while the output
// register was stalled. Used only when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Capture on load, drop the entry on clear (drain or flush).
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
            q_data <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with bubble insertion, flush and a saturating
// bubble counter. Define PIPE_SKID_EN to add a one-entry skid buffer,
// which makes in_ready independent of out_ready.
//
// Handshake: a transfer happens on a rising CLK edge where valid && ready;
// out_ctrl/out_data hold steady while out_valid=1 and out_ready=0.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output pipe_state_e       state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_e state;
    logic        up;
    logic        down;
    logic        can_load;
    logic        bubble_load;

    assign out_valid = (state != EMPTY);
    assign state_dbg = state;

`ifdef PIPE_SKID_EN
    // in_ready depends only on registered state plus bubble/flush.
    assign in_ready = Reset && (state != SKID) && !bubble && !flush;
`else
    // Single register: ready when empty or being drained this cycle.
    assign in_ready = Reset && (out_ready || (state == EMPTY)) && !bubble && !flush;
`endif

    assign up          = in_valid && in_ready;
    assign down        = out_valid && out_ready;
    assign can_load    = (state == EMPTY) || ((state == FULL) && out_ready);
    assign bubble_load = bubble && !flush && can_load;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_clear;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign skid_load  = (state == FULL) && up && !down;
    assign skid_clear = flush || ((state == SKID) && down);

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .CLK    (CLK),
        .Reset  (Reset),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );
`endif

    // Occupancy FSM, output register and bubble counter.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state      <= EMPTY;
            out_ctrl   <= '0;
            out_data   <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (bubble_load) begin
            state    <= FULL;
            out_ctrl <= {CTRL_W{NOP_CTRL_BIT}};
            out_data <= {DATA_W{NOP_DATA_BIT}};
            if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (up) begin
                        state    <= FULL;
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                    end
                end
                FULL: begin
                    if (up && down) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
`ifdef PIPE_SKID_EN
                    end else if (up) begin
                        state <= SKID;
`endif
                    end else if (down) begin
                        state <= EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                SKID: begin
                    if (down && skid_valid) begin
                        state    <= FULL;
                        out_ctrl <= skid_ctrl;
                        out_data <= skid_data;
                    end
                end
`endif
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios followed by random traffic,
// checked against a queue-based occupancy model. A second instance with a
// 2-bit counter shares the stimulus to cover counter saturation.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 96;
    localparam int W      = CTRL_W + DATA_W;
`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // ---------------- clock / reset ----------------
    logic CLK;
    logic Reset;
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              in_valid, bubble, flush, out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       bubble_cnt;
    pipe_state_e       state_dbg;

    logic              in_ready2, out_valid2;
    logic [CTRL_W-1:0] out_ctrl2;
    logic [DATA_W-1:0] out_data2;
    logic [1:0]        bubble_cnt2;
    pipe_state_e       state_dbg2;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .bubble(bubble), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .bubble_cnt(bubble_cnt), .state_dbg(state_dbg)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_data(in_data), .bubble(bubble), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
        .out_data(out_data2), .bubble_cnt(bubble_cnt2), .state_dbg(state_dbg2)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int  n_bubbles;
    bit  known;
    bit  last_rst;
    int  checks;
    int  passed;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic pipe_state_e exp_state();
        if (exp_q.size() == 0) return EMPTY;
        if (exp_q.size() == 1) return FULL;
        return SKID;
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive inputs, check current outputs and in_ready,
    // then advance the model by the coming edge.
    task automatic step(input logic rst_n, input logic iv, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic b, input logic f,
                        input logic ordy);
        logic exp_rdy;
        logic upx, downx, can_ld;
        @(negedge CLK);
        Reset = rst_n; in_valid = iv; in_ctrl = c; in_data = d;
        bubble = b; flush = f; out_ready = ordy;
        #1;
        if (!rst_n) exp_rdy = 1'b0;
        else if (DEPTH == 2) exp_rdy = (exp_q.size() < 2) && !b && !f;
        else exp_rdy = ((exp_q.size() == 0) || ordy) && !b && !f;
        check("in_ready", in_ready, exp_rdy);
        check("in_ready_w2", in_ready2, exp_rdy);
        if (known) begin
            check("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("out_ctrl", out_ctrl, exp_q[0][W-1:DATA_W]);
                check("out_data", out_data, exp_q[0][DATA_W-1:0]);
            end
            if (last_rst) begin
                check("rst_ctrl", out_ctrl, 0);
                check("rst_data", out_data, 0);
            end
            check("bubble_cnt", bubble_cnt, n_bubbles);
            check("bubble_cnt_w2", bubble_cnt2, (n_bubbles > 3) ? 3 : n_bubbles);
            check("state", state_dbg, exp_state());
            check("out_valid_w2", out_valid2, exp_q.size() > 0);
        end
        // model update for the next rising edge
        if (!rst_n) begin
            exp_q.delete();
            n_bubbles = 0;
            known = 1'b1;
            last_rst = 1'b1;
        end else if (known) begin
            last_rst = 1'b0;
            upx    = iv && exp_rdy;
            downx  = (exp_q.size() > 0) && ordy;
            can_ld = (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
            if (f) begin
                exp_q.delete();
            end else if (b && can_ld) begin
                if (downx) void'(exp_q.pop_front());
                exp_q.push_back('0);
                n_bubbles++;
            end else begin
                if (downx) void'(exp_q.pop_front());
                if (upx) exp_q.push_back({c, d});
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] rd;
        checks = 0; passed = 0; n_bubbles = 0; known = 1'b0; last_rst = 1'b0;
        Reset = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // reset held for two cycles, with traffic offered
        step(1'b0, 1'b1, 16'h55, 96'h55, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h66, 96'h66, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // stream of 8 entries with downstream always ready
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, CTRL_W'(i), DATA_W'(32'h100 + i), 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // two accepts while stalled, then drain
        step(1'b1, 1'b1, 16'hA1, 96'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hA2, 96'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hA3, 96'hA3, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // three bubbles with input offered: nothing consumed
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 16'hBB, 96'hBB, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // fill while stalled, then flush together with bubble
        step(1'b1, 1'b1, 16'hC1, 96'hC1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hC2, 96'hC2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hC3, 96'hC3, 1'b1, 1'b1, 1'b0);
        idle(1'b0);

        // stalled bubble is ignored, then two more counted bubbles
        step(1'b1, 1'b1, 16'hD1, 96'hD1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // reset in the middle of a transfer
        step(1'b1, 1'b1, 16'hE1, 96'hE1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hE2, 96'hE2, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom(), $urandom(), $urandom()};
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 3) != 0),
                 CTRL_W'($urandom()), rd,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
